// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MIPS memory stage: variable-latency dmem request bus and MEM/WB register
module mem_wb_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    input  logic [4:0]        WriteRegM,
    input  logic [31:0]       ALUOutM,
    input  logic [31:0]       WriteDataM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata,
    output logic              StallM,
    output logic              AlignErrM,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic [4:0]        WriteRegW,
    output logic [31:0]       ReadDataW,
    output logic [31:0]       ALUOutW,
    output logic [31:0]       ResultW
);

    typedef enum logic [0:0] {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic                dmem_req_q, dmem_req_d;
    logic                dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
    logic [31:0]         dmem_wdata_q, dmem_wdata_d;
    logic                reg_write_w_q, reg_write_w_d;
    logic                mem_to_reg_w_q, mem_to_reg_w_d;
    logic [4:0]          write_reg_w_q, write_reg_w_d;
    logic [31:0]         read_data_w_q, read_data_w_d;
    logic [31:0]         alu_out_w_q, alu_out_w_d;

    logic memop;
    logic misal;

    assign memop = MemtoRegM | MemWriteM;
    assign misal = memop & (ALUOutM[1:0] != 2'b00);

    // Stall while an aligned access is being launched or is still waiting for ready;
    // both outputs are forced low while reset is asserted.
    always_comb begin
        StallM    = 1'b0;
        AlignErrM = 1'b0;
        if (!reset) begin
            if (state_q == IDLE) begin
                StallM    = memop & ~misal;
                AlignErrM = misal;
            end else begin
                StallM    = ~dmem_ready;
            end
        end
    end

    // Next-state logic for the request FSM, the dmem bus registers and the MEM/WB register.
    always_comb begin
        state_d        = state_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_wdata_d   = dmem_wdata_q;
        // Default capture is a bubble; the address/data fields still track EX/MEM.
        reg_write_w_d  = 1'b0;
        mem_to_reg_w_d = 1'b0;
        write_reg_w_d  = WriteRegM;
        read_data_w_d  = read_data_w_q;
        alu_out_w_d    = ALUOutM;
        case (state_q)
            IDLE: begin
                if (!memop) begin
                    reg_write_w_d  = RegWriteM;
                    mem_to_reg_w_d = MemtoRegM;
                end else if (!misal) begin
                    state_d      = BUSY;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = MemWriteM;
                    dmem_addr_d  = ALUOutM[ADDR_W-1:0];
                    dmem_wdata_d = WriteDataM;
                end
            end
            BUSY: begin
                if (dmem_ready) begin
                    // EX/MEM was frozen during the access, so its fields still describe it.
                    state_d        = IDLE;
                    dmem_req_d     = 1'b0;
                    reg_write_w_d  = RegWriteM;
                    mem_to_reg_w_d = MemtoRegM;
                    if (!dmem_we_q) begin
                        read_data_w_d = dmem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register update with synchronous reset that wins from any state, including mid-access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_wdata_q   <= '0;
            reg_write_w_q  <= 1'b0;
            mem_to_reg_w_q <= 1'b0;
            write_reg_w_q  <= '0;
            read_data_w_q  <= '0;
            alu_out_w_q    <= '0;
        end else begin
            state_q        <= state_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_wdata_q   <= dmem_wdata_d;
            reg_write_w_q  <= reg_write_w_d;
            mem_to_reg_w_q <= mem_to_reg_w_d;
            write_reg_w_q  <= write_reg_w_d;
            read_data_w_q  <= read_data_w_d;
            alu_out_w_q    <= alu_out_w_d;
        end
    end

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign RegWriteW  = reg_write_w_q;
    assign MemtoRegW  = mem_to_reg_w_q;
    assign WriteRegW  = write_reg_w_q;
    assign ReadDataW  = read_data_w_q;
    assign ALUOutW    = alu_out_w_q;
    assign ResultW    = mem_to_reg_w_q ? read_data_w_q : alu_out_w_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk;
    logic        reset;
    logic        RegWriteM, MemtoRegM, MemWriteM;
    logic [4:0]  WriteRegM;
    logic [31:0] ALUOutM, WriteDataM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        StallM, AlignErrM;
    logic        RegWriteW, MemtoRegW;
    logic [4:0]  WriteRegW;
    logic [31:0] ReadDataW, ALUOutW, ResultW;

    int checks = 0;
    int errors = 0;

    // {WriteRegW, ResultW, MemtoRegW} for each retiring register write
    logic [37:0] wb_q[$];
    // {dmem_we, dmem_addr, dmem_wdata} for each issued request
    logic [64:0] req_q[$];

    mem_wb_stage #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .WriteRegM(WriteRegM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .StallM(StallM), .AlignErrM(AlignErrM),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .WriteRegW(WriteRegW),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .ResultW(ResultW)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_nop();
        RegWriteM  = 1'b0;
        MemtoRegM  = 1'b0;
        MemWriteM  = 1'b0;
        WriteRegM  = 5'd0;
        ALUOutM    = 32'd0;
        WriteDataM = 32'd0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'd0;
    endtask

    // Present one EX/MEM instruction, hold it while stalled, answer the request after
    // 'delay' BUSY cycles, and check stall and request-cycle counts.
    task automatic run_op(input logic rw, input logic mtr, input logic mw,
                          input logic [4:0] wreg, input logic [31:0] alu,
                          input logic [31:0] wd, input int delay,
                          input logic [31:0] rdata, input int exp_stall,
                          input string name);
        int stalls = 0;
        int req_cycles = 0;
        int busy = 0;
        bit done = 0;
        logic st;
        if (rw) wb_q.push_back({wreg, (mtr ? rdata : alu), mtr});
        if (mtr | mw) req_q.push_back({mw, alu, wd});
        RegWriteM  = rw;
        MemtoRegM  = mtr;
        MemWriteM  = mw;
        WriteRegM  = wreg;
        ALUOutM    = alu;
        WriteDataM = wd;
        for (int cyc = 0; cyc < 50 && !done; cyc++) begin
            if (dmem_req) begin
                dmem_ready = (busy == delay);
                dmem_rdata = dmem_ready ? rdata : 32'h0;
                busy++;
            end else begin
                dmem_ready = 1'b0;
            end
            @(negedge clk);
            st = StallM;
            if (st) stalls++;
            if (dmem_req) req_cycles++;
            @(posedge clk);
            #1;
            if (!st) done = 1;
        end
        check({name, "_done"}, 65'(done), 65'd1);
        check({name, "_stall_cycles"}, 65'(stalls), 65'(exp_stall));
        check({name, "_req_cycles"}, 65'(req_cycles), 65'((mtr | mw) ? 1 + delay : 0));
        set_nop();
    endtask

    // Write-back monitor: every cycle with RegWriteW=1 is one retirement.
    initial begin
        logic [37:0] e;
        forever begin
            @(negedge clk);
            if (!reset && RegWriteW) begin
                if (wb_q.size() == 0) begin
                    check("wb_unexpected_retire", 65'(WriteRegW), 65'h1f_dead);
                end else begin
                    e = wb_q.pop_front();
                    check("wb_WriteRegW", 65'(WriteRegW), 65'(e[37:33]));
                    check("wb_ResultW", 65'(ResultW), 65'(e[32:1]));
                    check("wb_MemtoRegW", 65'(MemtoRegW), 65'(e[0]));
                end
            end
        end
    end

    // Request monitor: each rising dmem_req is one request; fields must stay stable while high.
    initial begin
        logic        req_prev = 1'b0;
        logic [64:0] held = '0;
        forever begin
            @(negedge clk);
            if (dmem_req && !req_prev) begin
                held = {dmem_we, dmem_addr, dmem_wdata};
                if (req_q.size() == 0) begin
                    check("req_unexpected_issue", 65'(dmem_addr), 65'h1_dead_beef);
                end else begin
                    check("req_fields", held, req_q.pop_front());
                end
            end else if (dmem_req && req_prev) begin
                check("req_held_stable", {dmem_we, dmem_addr, dmem_wdata}, held);
            end
            req_prev = dmem_req;
        end
    end

    initial begin
        set_nop();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_dmem_req", 65'(dmem_req), 65'd0);
        check("rst_W_outputs", {RegWriteW, MemtoRegW, WriteRegW, ReadDataW}, 65'd0);
        check("rst_ALUOutW", 65'(ALUOutW), 65'd0);
        check("rst_StallM", 65'(StallM), 65'd0);
        @(posedge clk);
        #1;

        // ALU op retires next cycle with no stall
        run_op(1'b1, 1'b0, 1'b0, 5'd8, 32'h0000_002A, 32'h0, 0, 32'h0, 0, "alu");
        // Load, ready on first BUSY cycle
        run_op(1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 1, "load");
        // Store, ready after 3 extra cycles
        run_op(1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_0204, 32'h1234_5678, 3, 32'h0, 4, "store");

        // Misaligned load is dropped with a one-cycle error pulse
        RegWriteM = 1'b1;
        MemtoRegM = 1'b1;
        WriteRegM = 5'd7;
        ALUOutM   = 32'h0000_0103;
        @(negedge clk);
        check("misal_AlignErrM", 65'(AlignErrM), 65'd1);
        check("misal_StallM", 65'(StallM), 65'd0);
        @(posedge clk);
        #1;
        set_nop();
        @(negedge clk);
        check("misal_pulse_end", 65'(AlignErrM), 65'd0);
        check("misal_no_req", 65'(dmem_req), 65'd0);
        check("misal_bubble", {RegWriteW, MemtoRegW}, 65'd0);
        @(posedge clk);
        #1;

        // Back-to-back loads
        run_op(1'b1, 1'b1, 1'b0, 5'd10, 32'h0000_0010, 32'h0, 0, 32'hA5A5_0001, 1, "b2b_load0");
        run_op(1'b1, 1'b1, 1'b0, 5'd11, 32'h0000_0014, 32'h0, 0, 32'h5A5A_0002, 1, "b2b_load1");

        // Reset during BUSY, then a late ready
        RegWriteM = 1'b1;
        MemtoRegM = 1'b1;
        WriteRegM = 5'd12;
        ALUOutM   = 32'h0000_0040;
        req_q.push_back({1'b0, 32'h0000_0040, 32'h0});
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_busy_StallM_low", 65'(StallM), 65'd0);
        check("rst_busy_AlignErrM_low", 65'(AlignErrM), 65'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_nop();
        dmem_ready = 1'b1;
        dmem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        check("rst_mid_dmem_bus", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, 65'd0);
        check("rst_mid_W_outputs", {RegWriteW, MemtoRegW, WriteRegW, ReadDataW}, 65'd0);
        check("rst_mid_ALUOutW", 65'(ALUOutW), 65'd0);
        check("rst_mid_StallM", 65'(StallM), 65'd0);
        @(posedge clk);
        #1;
        dmem_ready = 1'b0;
        @(negedge clk);
        check("late_ready_ReadDataW", 65'(ReadDataW), 65'd0);
        check("late_ready_no_req", 65'(dmem_req), 65'd0);
        @(posedge clk);
        #1;

        // Pipeline resumes from IDLE after reset
        run_op(1'b1, 1'b0, 1'b0, 5'd3, 32'h0000_0077, 32'h0, 0, 32'h0, 0, "post_rst_alu");
        run_op(1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_0080, 32'h0, 1, 32'hCAFE_F00D, 2, "post_rst_load");

        repeat (3) @(negedge clk);
        check("wb_queue_drained", 65'(wb_q.size()), 65'd0);
        check("req_queue_drained", 65'(req_q.size()), 65'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
